dma_job_sched: RTL and testbench
================================

Name: dma_job_sched

Overview:
Multi-channel job scheduler in front of the p-core DMA engine. It accepts transfer jobs (src, dst, len) from NUM_CH requesters, such as core CSR shims or peripheral handshakes, and picks one by round-robin. It issues that job to the DMA's job port and tracks completion. Only one job is outstanding at a time. A watchdog aborts jobs that never complete.

Parameters:
NUM_CH, 4, number of requester channels (2..16)
ADDR_W, 32, source/destination address width
LEN_W, 16, byte-length width
TIMEOUT, 4096, max cycles in WAIT before abort (>=2)

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  reset; synchronous, active-high
ch_valid_i  in  NUM_CH  per-channel job request valid
ch_ready_o  out  NUM_CH  per-channel accept; one-hot or zero
ch_src_i  in  NUM_CH*ADDR_W  packed source addresses; channel k at [k*ADDR_W +: ADDR_W]
ch_dst_i  in  NUM_CH*ADDR_W  packed destination addresses
ch_len_i  in  NUM_CH*LEN_W  packed byte lengths
job_valid_o  out  1  job offered to DMA
job_ready_i  in  1  DMA accepts job
job_src_o  out  ADDR_W  latched source address
job_dst_o  out  ADDR_W  latched destination address
job_len_o  out  LEN_W  latched length
job_id_o  out  CH_W  owning channel; CH_W = max(1, $clog2(NUM_CH))
dma_done_i  in  1  DMA completion pulse
dma_err_i  in  1  DMA error pulse
ch_done_o  out  NUM_CH  one-cycle completion pulse per channel
ch_err_o  out  NUM_CH  one-cycle error or timeout pulse per channel
timeout_o  out  1  one-cycle pulse when the watchdog fires
busy_o  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- Reset: state=IDLE; rr_ptr=0; job_* regs=0. All outputs 0: ch_ready_o, job_valid_o, ch_done_o, ch_err_o, timeout_o, busy_o.
- IDLE arbitration:
  - Round-robin search over ch_valid_i, starting at rr_ptr and wrapping at NUM_CH.
  - ch_ready_o = one-hot of the winner. This is combinational, in IDLE only. It is 0 in all other states.
  - Handshake on winner valid&&ready: latch src/dst/len/id; rr_ptr <= winner+1, wrapping NUM_CH-1 -> 0.
- Zero length (len==0): job is accepted but not issued. ch_done_o[id] pulses the next cycle. State stays IDLE.
- Nonzero length: next state is ISSUE. job_valid_o rises in the cycle after acceptance (latency 1).
- ISSUE:
  - job_valid_o=1; job_* held stable until job_ready_i.
  - On valid&&ready: go to WAIT and clear the watchdog counter.
  - Reset is the only way to abandon ISSUE.
- WAIT:
  - Watchdog counter increments each cycle.
  - dma_done_i: ch_done_o[id] pulses next cycle; go to IDLE.
  - dma_err_i: ch_err_o[id] pulses next cycle; go to IDLE.
  - done and err in the same cycle: err wins; only ch_err_o pulses.
  - Counter reaching TIMEOUT-1 without done/err: ch_err_o[id] and timeout_o pulse next cycle; go to IDLE.
  - done/err in the same cycle the timeout would fire: done/err wins; no timeout.
- dma_done_i / dma_err_i arriving in IDLE or ISSUE: ignored, no pulse.
- Back-to-back: the completion cycle returns to IDLE, so the next arbitration and accept can happen in that same IDLE cycle. Completion pulses and the next accept may coincide.
- Reset mid-operation (ISSUE or WAIT):
  - Job dropped; state=IDLE next cycle.
  - No done/err pulse for the dropped job.
  - rr_ptr returns to 0.
- Pulses: ch_done_o and ch_err_o are registered and at most one bit is set per cycle.
- Requesters must hold ch_*_i stable while valid is high and not yet accepted.

Optional Feature:
DMA_SCHED_PRIO_EN
- Defined: channel 0 has strict priority. If ch_valid_i[0]=1 in IDLE, channel 0 wins regardless of rr_ptr, and rr_ptr is not updated by a channel-0 grant. Channels 1..NUM_CH-1 use round-robin among themselves.
- Undefined: pure round-robin over all channels, as specified above.

Test Plan:
- Reset, then ch_valid_i=4'b0000 -> all outputs 0, busy_o=0 for 10 cycles.
- ch2 job (src=0x1000, dst=0x2000, len=64) accepted at cycle T:
  - job_valid_o=1 at T+1 with job_id_o=2.
  - job_ready_i at T+3 -> WAIT.
  - dma_done_i at T+10 -> ch_done_o=4'b0100 at T+11; busy_o=0 at T+11.
- ch_valid_i=4'b1111 held; DMA completes each job in 5 cycles -> grant order 0,1,2,3,0; no channel granted twice before all others (macro undefined).
- ch1 len=0 -> ch_ready_o[1] pulse, ch_done_o=4'b0010 next cycle, job_valid_o never rises.
- Job issued, no completion, TIMEOUT=16 -> ch_err_o[id] and timeout_o pulse exactly 16 cycles after the ISSUE handshake; a later dma_done_i in IDLE produces no pulse.
- dma_done_i and dma_err_i together in WAIT -> only ch_err_o pulses. rst_i asserted in WAIT -> IDLE next cycle, no pulse, rr_ptr=0 (next grant starts from ch0).

Source files
------------

// File: rtl/dma_job_sched.sv
// dma_job_sched: picks one of NUM_CH requesters' transfer jobs, offers it to
// the DMA job port, and waits for done/error with a watchdog abort.
// Only one job is in flight at a time.
//
// Optional build macro DMA_SCHED_PRIO_EN: channel 0 gets strict priority over
// the round-robin ring, and a channel-0 grant leaves the ring pointer alone.
// Without it, all channels share one round-robin ring.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no job held; arbitrate and accept a request
// ST_ISSUE | job latched, job_valid_o high until the DMA takes it
// ST_WAIT  | DMA owns the job; watchdog counting toward TIMEOUT
module dma_job_sched #(
   parameter  int NUM_CH  = 4,
   parameter  int ADDR_W  = 32,
   parameter  int LEN_W   = 16,
   parameter  int TIMEOUT = 4096,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_CH-1:0]        ch_valid_i,
   output logic [NUM_CH-1:0]        ch_ready_o,
   input  logic [NUM_CH*ADDR_W-1:0] ch_src_i,
   input  logic [NUM_CH*ADDR_W-1:0] ch_dst_i,
   input  logic [NUM_CH*LEN_W-1:0]  ch_len_i,
   output logic                     job_valid_o,
   input  logic                     job_ready_i,
   output logic [ADDR_W-1:0]        job_src_o,
   output logic [ADDR_W-1:0]        job_dst_o,
   output logic [LEN_W-1:0]         job_len_o,
   output logic [CH_W-1:0]          job_id_o,
   input  logic                     dma_done_i,
   input  logic                     dma_err_i,
   output logic [NUM_CH-1:0]        ch_done_o,
   output logic [NUM_CH-1:0]        ch_err_o,
   output logic                     timeout_o,
   output logic                     busy_o
);

   localparam int WD_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [CH_W-1:0]     rr_ptr;
   logic [CH_W-1:0]     win;
   logic                found;
   logic                accept;
   logic                wd_expire;
   logic [NUM_CH-1:0]   win_oh, id_oh;
   logic [NUM_CH-1:0]   done_nxt, err_nxt;
   logic                to_nxt;
   logic [NUM_CH-1:0]   ch_done_q, ch_err_q;
   logic                to_q;
   logic [WD_W-1:0]     wd_cnt;
   logic [ADDR_W-1:0]   job_src, job_dst, sel_src, sel_dst;
   logic [LEN_W-1:0]    job_len, sel_len;
   logic [CH_W-1:0]     job_id;
   logic [CH_W-1:0]     rr_next;

   // Round-robin search starting at rr_ptr; channel 0 may pre-empt the ring.
   always_comb begin : arb_search
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
`ifdef DMA_SCHED_PRIO_EN
      if (ch_valid_i[0]) begin
         found = 1'b1;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && idx != 0 && ch_valid_i[idx]) begin
               found = 1'b1;
               win   = CH_W'(idx);
            end
         end
      end
`else
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && ch_valid_i[idx]) begin
            found = 1'b1;
            win   = CH_W'(idx);
         end
      end
`endif
   end

   // Winner/owner one-hots and the winner's job fields.
   always_comb begin
      win_oh         = '0;
      win_oh[win]    = found;
      id_oh          = '0;
      id_oh[job_id]  = 1'b1;
      sel_src        = ch_src_i[int'(win)*ADDR_W +: ADDR_W];
      sel_dst        = ch_dst_i[int'(win)*ADDR_W +: ADDR_W];
      sel_len        = ch_len_i[int'(win)*LEN_W +: LEN_W];
      rr_next        = (win == CH_W'(NUM_CH-1)) ? '0 : win + CH_W'(1);
   end

   // Ready is only ever offered to the winner, and never while in reset.
   assign accept     = (state == ST_IDLE) && found && !rst_i;
   assign ch_ready_o = accept ? win_oh : '0;
   assign wd_expire  = (wd_cnt == WD_W'(TIMEOUT-1));

   // Next state and next-cycle completion pulses.
   always_comb begin
      state_nxt = state;
      done_nxt  = '0;
      err_nxt   = '0;
      to_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (sel_len == '0) done_nxt  = win_oh;
               else               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (job_ready_i) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (dma_err_i) begin
               err_nxt   = id_oh;
               state_nxt = ST_IDLE;
            end else if (dma_done_i) begin
               done_nxt  = id_oh;
               state_nxt = ST_IDLE;
            end else if (wd_expire) begin
               err_nxt   = id_oh;
               to_nxt    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Registered completion pulses; reset drops any pending pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ch_done_q <= '0;
         ch_err_q  <= '0;
         to_q      <= 1'b0;
      end else begin
         ch_done_q <= done_nxt;
         ch_err_q  <= err_nxt;
         to_q      <= to_nxt;
      end
   end

   // Job latch, ring pointer and watchdog.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr  <= '0;
         job_src <= '0;
         job_dst <= '0;
         job_len <= '0;
         job_id  <= '0;
         wd_cnt  <= '0;
      end else begin
         if (accept) begin
            job_src <= sel_src;
            job_dst <= sel_dst;
            job_len <= sel_len;
            job_id  <= win;
`ifdef DMA_SCHED_PRIO_EN
            if (win != '0) rr_ptr <= rr_next;
`else
            rr_ptr <= rr_next;
`endif
         end
         if (state == ST_ISSUE)     wd_cnt <= '0;
         else if (state == ST_WAIT) wd_cnt <= wd_cnt + WD_W'(1);
      end
   end

   assign job_valid_o = (state == ST_ISSUE);
   assign job_src_o   = job_src;
   assign job_dst_o   = job_dst;
   assign job_len_o   = job_len;
   assign job_id_o    = job_id;
   assign ch_done_o   = ch_done_q;
   assign ch_err_o    = ch_err_q;
   assign timeout_o   = to_q;
   assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_dma_job_sched.sv
// Bench for dma_job_sched: a job-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dma_job_sched;

   localparam int NUM_CH  = 4;
   localparam int ADDR_W  = 32;
   localparam int LEN_W   = 16;
   localparam int TIMEOUT = 16;
   localparam int CH_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst_i = 1'b1;
   logic [NUM_CH-1:0]        ch_valid = '0;
   logic [NUM_CH-1:0]        ch_ready_o;
   logic [NUM_CH*ADDR_W-1:0] ch_src = '0;
   logic [NUM_CH*ADDR_W-1:0] ch_dst = '0;
   logic [NUM_CH*LEN_W-1:0]  ch_len = '0;
   logic                     job_valid_o;
   logic                     job_ready = 1'b0;
   logic [ADDR_W-1:0]        job_src_o, job_dst_o;
   logic [LEN_W-1:0]         job_len_o;
   logic [CH_W-1:0]          job_id_o;
   logic                     dma_done = 1'b0, dma_err = 1'b0;
   logic [NUM_CH-1:0]        ch_done_o, ch_err_o;
   logic                     timeout_o, busy_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   dma_job_sched #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .ch_valid_i(ch_valid), .ch_ready_o(ch_ready_o),
      .ch_src_i(ch_src), .ch_dst_i(ch_dst), .ch_len_i(ch_len),
      .job_valid_o(job_valid_o), .job_ready_i(job_ready),
      .job_src_o(job_src_o), .job_dst_o(job_dst_o), .job_len_o(job_len_o), .job_id_o(job_id_o),
      .dma_done_i(dma_done), .dma_err_i(dma_err),
      .ch_done_o(ch_done_o), .ch_err_o(ch_err_o),
      .timeout_o(timeout_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (job level) ----------------
   int               m_ptr = 0;
   bit               m_busy = 0, m_issued = 0;
   int               m_wait = 0;
   int               m_id = 0;
   int               m_win;
   int               m_idx;
   logic [ADDR_W-1:0] m_src = '0, m_dst = '0;
   logic [LEN_W-1:0]  m_len = '0;
   logic [NUM_CH-1:0] m_pdone = '0, m_perr = '0, m_ready;
   bit               m_pto = 0;

   always @(negedge clk) begin
      if (rst_i) begin
         m_ptr = 0; m_busy = 0; m_issued = 0; m_wait = 0;
         m_pdone = '0; m_perr = '0; m_pto = 0;
      end else begin
         m_win = -1;
         if (!m_busy) begin
            for (int k = 0; k < NUM_CH; k++) begin
               m_idx = (m_ptr + k) % NUM_CH;
               if (m_win < 0 && ch_valid[m_idx]) m_win = m_idx;
            end
         end
         m_ready = '0;
         if (m_win >= 0) m_ready[m_win] = 1'b1;

         check("m_ch_ready", ch_ready_o, m_ready);
         check("m_busy", busy_o, m_busy);
         check("m_job_valid", job_valid_o, m_busy && !m_issued);
         check("m_ch_done", ch_done_o, m_pdone);
         check("m_ch_err", ch_err_o, m_perr);
         check("m_timeout", timeout_o, m_pto);
         if (m_busy && !m_issued) begin
            check("m_job_src", job_src_o, m_src);
            check("m_job_dst", job_dst_o, m_dst);
            check("m_job_len", job_len_o, m_len);
            check("m_job_id", job_id_o, m_id);
         end

         m_pdone = '0; m_perr = '0; m_pto = 0;
         if (!m_busy) begin
            if (m_win >= 0) begin
               m_ptr = (m_win + 1) % NUM_CH;
               if (ch_len[m_win*LEN_W +: LEN_W] == '0) begin
                  m_pdone[m_win] = 1'b1;
               end else begin
                  m_busy = 1; m_issued = 0; m_id = m_win;
                  m_src = ch_src[m_win*ADDR_W +: ADDR_W];
                  m_dst = ch_dst[m_win*ADDR_W +: ADDR_W];
                  m_len = ch_len[m_win*LEN_W +: LEN_W];
               end
            end
         end else if (!m_issued) begin
            if (job_ready) begin m_issued = 1; m_wait = 0; end
         end else begin
            m_wait++;
            if (dma_err)                 begin m_perr[m_id] = 1'b1; m_busy = 0; end
            else if (dma_done)           begin m_pdone[m_id] = 1'b1; m_busy = 0; end
            else if (m_wait == TIMEOUT)  begin m_perr[m_id] = 1'b1; m_pto = 1; m_busy = 0; end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_job(input int ch, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [LEN_W-1:0] l);
      ch_src[ch*ADDR_W +: ADDR_W] = s;
      ch_dst[ch*ADDR_W +: ADDR_W] = d;
      ch_len[ch*LEN_W +: LEN_W]   = l;
   endtask

   // Waits (bounded) for job_valid_o, then completes the handshake.
   task automatic handshake(output int hs_cyc);
      for (int i = 0; i < 20; i++) begin
         if (job_valid_o) break;
         tick();
      end
      check("hs_job_valid_seen", job_valid_o, 1'b1);
      job_ready = 1'b1;
      hs_cyc = cyc;
      tick();
      job_ready = 1'b0;
   endtask

   int grants[5];
   int ngr, rem, hs, to_cyc, g;

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      rst_i = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", busy_o, 1'b0);
         check("idle_ready", ch_ready_o, 4'b0000);
         tick();
      end

      // Single ch2 job with done at T+10.
      set_job(2, 32'h1000, 32'h2000, 16'd64);
      ch_valid = 4'b0100;
      @(negedge clk);
      check("t2_ready", ch_ready_o, 4'b0100);
      tick();
      ch_valid = '0;
      @(negedge clk);
      check("t2_job_valid", job_valid_o, 1'b1);
      check("t2_job_id", job_id_o, 2);
      check("t2_job_src", job_src_o, 32'h1000);
      check("t2_job_dst", job_dst_o, 32'h2000);
      check("t2_job_len", job_len_o, 64);
      tick();
      tick();
      job_ready = 1'b1;
      tick();
      job_ready = 1'b0;
      @(negedge clk);
      check("t2_wait_busy", busy_o, 1'b1);
      check("t2_wait_valid", job_valid_o, 1'b0);
      repeat (6) tick();
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      @(negedge clk);
      check("t2_done", ch_done_o, 4'b0100);
      check("t2_busy_off", busy_o, 1'b0);

      // Fresh ring, all channels requesting, DMA takes 5 cycles per job.
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
         set_job(c, 32'h100 * (c + 1), 32'h8000 + 32'h10 * c, LEN_W'(16 + c));
      ch_valid = 4'b1111;
      ngr = 0; rem = 0;
      for (int i = 0; i < 200 && !(ngr >= 5 && !busy_o && rem == 0); i++) begin
         @(negedge clk);
         if (ch_ready_o != '0 && ngr < 5) begin
            g = -1;
            for (int k = 0; k < NUM_CH; k++) if (ch_ready_o[k]) g = k;
            grants[ngr] = g;
            ngr++;
         end
         tick();
         job_ready = 1'b0;
         dma_done  = 1'b0;
         if (ngr >= 5) ch_valid = '0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) dma_done = 1'b1;
         end else if (job_valid_o) begin
            job_ready = 1'b1;
            rem = 5;
         end
      end
      job_ready = 1'b0; dma_done = 1'b0; ch_valid = '0;
      check("rr_grant_count", ngr, 5);
      check("rr_grant0", grants[0], 0);
      check("rr_grant1", grants[1], 1);
      check("rr_grant2", grants[2], 2);
      check("rr_grant3", grants[3], 3);
      check("rr_grant4", grants[4], 0);

      // Zero-length job on ch1: done pulse, never issued.
      tick();
      set_job(1, 32'hAAAA, 32'hBBBB, 16'd0);
      ch_valid = 4'b0010;
      @(negedge clk);
      check("z_ready", ch_ready_o, 4'b0010);
      tick();
      ch_valid = '0;
      @(negedge clk);
      check("z_done", ch_done_o, 4'b0010);
      check("z_no_valid", job_valid_o, 1'b0);
      tick();
      @(negedge clk);
      check("z_no_valid2", job_valid_o, 1'b0);
      check("z_busy", busy_o, 1'b0);

      // Watchdog on ch3; dma_done in ISSUE and later in IDLE is ignored.
      tick();
      set_job(3, 32'h3000, 32'h4000, 16'd8);
      ch_valid = 4'b1000;
      tick();
      ch_valid = '0;
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      @(negedge clk);
      check("to_issue_done_ignored", ch_done_o, 4'b0000);
      handshake(hs);
      to_cyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (timeout_o) begin
            to_cyc = cyc;
            break;
         end
         tick();
      end
      check("to_delay_edges", to_cyc - (hs + 1), 16);
      check("to_err", ch_err_o, 4'b1000);
      tick();
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      @(negedge clk);
      check("to_late_done", ch_done_o, 4'b0000);
      check("to_late_err", ch_err_o, 4'b0000);

      // dma_done on the very cycle the watchdog would fire: done wins.
      tick();
      set_job(1, 32'h5000, 32'h6000, 16'd4);
      ch_valid = 4'b0010;
      tick();
      ch_valid = '0;
      handshake(hs);
      repeat (15) tick();
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      @(negedge clk);
      check("edge_done", ch_done_o, 4'b0010);
      check("edge_no_timeout", timeout_o, 1'b0);
      check("edge_no_err", ch_err_o, 4'b0000);

      // done and err together: error wins.
      tick();
      set_job(0, 32'h7000, 32'h7100, 16'd12);
      ch_valid = 4'b0001;
      tick();
      ch_valid = '0;
      handshake(hs);
      repeat (3) tick();
      dma_done = 1'b1;
      dma_err  = 1'b1;
      tick();
      dma_done = 1'b0;
      dma_err  = 1'b0;
      @(negedge clk);
      check("both_err", ch_err_o, 4'b0001);
      check("both_no_done", ch_done_o, 4'b0000);

      // Reset while in WAIT: job dropped silently, ring restarts at ch0.
      tick();
      set_job(2, 32'h9000, 32'h9100, 16'd20);
      ch_valid = 4'b0100;
      tick();
      ch_valid = '0;
      handshake(hs);
      tick();
      rst_i    = 1'b1;
      dma_done = 1'b1;
      tick();
      rst_i    = 1'b0;
      dma_done = 1'b0;
      @(negedge clk);
      check("rst_busy", busy_o, 1'b0);
      check("rst_no_done", ch_done_o, 4'b0000);
      check("rst_no_err", ch_err_o, 4'b0000);
      tick();
      set_job(1, 32'h5000, 32'h6000, 16'd4);
      ch_valid = 4'b1111;
      @(negedge clk);
      check("rst_next_grant", ch_ready_o, 4'b0001);
      tick();
      ch_valid = '0;
      handshake(hs);
      repeat (3) tick();
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
